// File: rtl/spi_flash_reader.sv
// Read sequencer for a W25Q-series SPI flash sitting in front of a byte-level SPI controller.
// Sends opcode, 24-bit address, optional dummy bytes, then streams len bytes over valid/ready.
module spi_flash_reader #(
   parameter logic [7:0] CMD_READ    = 8'h03,
   parameter int         DUMMY_BYTES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [23:0] addr,
   input  logic [15:0] len,
   output logic        busy,
   output logic        done,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        spi_load,
   output logic [15:0] spi_in,
   input  logic [15:0] spi_out
);

   typedef enum logic [3:0] {
      IDLE, PRE_DESEL, CMD, ADDR, DUMMY, DATA, HOLD, END_DESEL, DONE
   } state_t;

   typedef enum logic [1:0] {P_ISSUE, P_GUARD, P_WAIT} phase_t;

   localparam logic [15:0] DESEL_WORD = 16'h0100;
   localparam logic [7:0]  DUMMY_LAST = (DUMMY_BYTES > 0) ? 8'(DUMMY_BYTES - 1) : 8'd0;

   state_t      state;
   phase_t      phase;
   logic [23:0] addr_q;
   logic [15:0] remaining;
   logic [1:0]  addr_cnt;
   logic [7:0]  dummy_cnt;
   logic        need_desel;
   logic        byte_done;
   logic        unused_status;

   // The controller's busy flag lags the load strobe, so it is only trusted after the guard cycle.
   assign byte_done     = (phase == P_WAIT) && !spi_out[15];
   assign unused_status = ^spi_out[14:8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         phase      <= P_WAIT;
         addr_q     <= '0;
         remaining  <= '0;
         addr_cnt   <= '0;
         dummy_cnt  <= '0;
         need_desel <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         spi_load   <= 1'b0;
         spi_in     <= '0;
      end else begin
         spi_load <= 1'b0;
         done     <= 1'b0;
         if (phase == P_ISSUE)
            phase <= P_GUARD;
         else if (phase == P_GUARD)
            phase <= P_WAIT;

         case (state)
            IDLE: begin
               // A request coinciding with the done pulse belongs to the finished transaction.
               if (req && !done) begin
                  addr_q    <= addr;
                  remaining <= len;
                  busy      <= 1'b1;
                  if (len == 16'd0) begin
                     state <= DONE;
                  end else if (need_desel) begin
                     state      <= PRE_DESEL;
                     spi_load   <= 1'b1;
                     spi_in     <= DESEL_WORD;
                     phase      <= P_ISSUE;
                     need_desel <= 1'b0;
                  end else begin
                     state    <= CMD;
                     spi_load <= 1'b1;
                     spi_in   <= {8'h00, CMD_READ};
                     phase    <= P_ISSUE;
                  end
               end
            end

            PRE_DESEL: begin
               if (phase == P_GUARD) begin
                  state    <= CMD;
                  spi_load <= 1'b1;
                  spi_in   <= {8'h00, CMD_READ};
                  phase    <= P_ISSUE;
               end
            end

            CMD: begin
               if (byte_done) begin
                  state    <= ADDR;
                  addr_cnt <= 2'd0;
                  spi_load <= 1'b1;
                  spi_in   <= {8'h00, addr_q[23:16]};
                  phase    <= P_ISSUE;
               end
            end

            ADDR: begin
               if (byte_done) begin
                  spi_load <= 1'b1;
                  phase    <= P_ISSUE;
                  if (addr_cnt == 2'd2) begin
                     spi_in    <= 16'h0000;
                     dummy_cnt <= 8'd0;
                     state     <= (DUMMY_BYTES > 0) ? DUMMY : DATA;
                  end else begin
                     addr_cnt <= addr_cnt + 2'd1;
                     spi_in   <= {8'h00, (addr_cnt == 2'd0) ? addr_q[15:8] : addr_q[7:0]};
                  end
               end
            end

            DUMMY: begin
               if (byte_done) begin
                  spi_load <= 1'b1;
                  spi_in   <= 16'h0000;
                  phase    <= P_ISSUE;
                  if (dummy_cnt == DUMMY_LAST)
                     state <= DATA;
                  else
                     dummy_cnt <= dummy_cnt + 8'd1;
               end
            end

            DATA: begin
               if (byte_done) begin
                  rd_data  <= spi_out[7:0];
                  rd_valid <= 1'b1;
                  state    <= HOLD;
               end
            end

            HOLD: begin
               if (rd_ready) begin
                  rd_valid  <= 1'b0;
                  remaining <= remaining - 16'd1;
                  spi_load  <= 1'b1;
                  phase     <= P_ISSUE;
                  if (remaining > 16'd1) begin
                     state  <= DATA;
                     spi_in <= 16'h0000;
                  end else begin
                     state      <= END_DESEL;
                     spi_in     <= DESEL_WORD;
                     need_desel <= 1'b0;
                  end
               end
            end

            END_DESEL: begin
               if (phase == P_GUARD)
                  state <= DONE;
            end

            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural byte-level SPI controller per instance.
// Instance 0 uses the default read opcode; instance 1 uses fast read with one dummy byte.
module tb_spi_flash_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, req1;
   logic [23:0] addr, addr1;
   logic [15:0] len, len1;
   logic        rd_ready, rd_ready1;

   logic        busy0, done0, rd_valid0, spi_load0;
   logic [7:0]  rd_data0;
   logic [15:0] spi_in0, spi_out0;
   logic        busy1, done1, rd_valid1, spi_load1;
   logic [7:0]  rd_data1;
   logic [15:0] spi_in1, spi_out1;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] log0[$], log1[$];
   logic [7:0]  got0[$], got1[$], rxq0[$], rxq1[$];
   int          done_cnt0 = 0;
   int          m_idx0 = 0, m_idx1 = 0;
   logic        m_busy0 = 1'b0, m_busy1 = 1'b0;
   logic [2:0]  m_cnt0 = '0, m_cnt1 = '0;
   logic [7:0]  m_pend0 = '0, m_pend1 = '0, m_rx0 = '0, m_rx1 = '0;

   always #5 clk = ~clk;

   spi_flash_reader dut0 (
      .clk(clk), .reset(reset), .req(req), .addr(addr), .len(len),
      .busy(busy0), .done(done0), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .rd_ready(rd_ready), .spi_load(spi_load0), .spi_in(spi_in0), .spi_out(spi_out0)
   );

   spi_flash_reader #(.CMD_READ(8'h0B), .DUMMY_BYTES(1)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .addr(addr1), .len(len1),
      .busy(busy1), .done(done1), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .rd_ready(rd_ready1), .spi_load(spi_load1), .spi_in(spi_in1), .spi_out(spi_out1)
   );

   assign spi_out0 = {m_busy0, 7'b0, m_rx0};
   assign spi_out1 = {m_busy1, 7'b0, m_rx1};

   // Controller model: a byte transfer stays busy for 4 cycles, then presents the next queued rx byte.
   always @(posedge clk) begin
      if (spi_load0) log0.push_back(spi_in0);
      if (rd_valid0 && rd_ready) got0.push_back(rd_data0);
      if (done0) done_cnt0++;
      if (spi_load0 && !spi_in0[8]) begin
         m_busy0 <= 1'b1;
         m_cnt0  <= 3'd3;
         m_pend0 <= (m_idx0 < rxq0.size()) ? rxq0[m_idx0] : 8'hFF;
         m_idx0++;
      end else if (m_busy0) begin
         if (m_cnt0 == 3'd0) begin
            m_busy0 <= 1'b0;
            m_rx0   <= m_pend0;
         end else begin
            m_cnt0 <= m_cnt0 - 3'd1;
         end
      end
   end

   always @(posedge clk) begin
      if (spi_load1) log1.push_back(spi_in1);
      if (rd_valid1 && rd_ready1) got1.push_back(rd_data1);
      if (spi_load1 && !spi_in1[8]) begin
         m_busy1 <= 1'b1;
         m_cnt1  <= 3'd3;
         m_pend1 <= (m_idx1 < rxq1.size()) ? rxq1[m_idx1] : 8'hFF;
         m_idx1++;
      end else if (m_busy1) begin
         if (m_cnt1 == 3'd0) begin
            m_busy1 <= 1'b0;
            m_rx1   <= m_pend1;
         end else begin
            m_cnt1 <= m_cnt1 - 3'd1;
         end
      end
   end

   task automatic start0(input logic [23:0] a, input logic [15:0] l);
      @(negedge clk);
      req  = 1'b1;
      addr = a;
      len  = l;
      @(negedge clk);
      req  = 1'b0;
      addr = 24'hFFFFFF;
      len  = 16'hFFFF;
   endtask

   task automatic wait_done0(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (done0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid0(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rd_valid0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors += 6;
      if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy0); end
      if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done0); end
      if (rd_valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rd_valid0); end
      if (rd_data0 !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rd_data: got %h want 00", rd_data0); end
      if (spi_load0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_spi_load: got %b want 0", spi_load0); end
      if (spi_in0 !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_spi_in: got %h want 0000", spi_in0); end
   endtask

   task automatic test_first_read;
      logic [15:0] exp_log[8];
      logic [7:0]  exp_got[2];
      int lb, gb, db;
      bit ok;
      exp_log = '{16'h0100, 16'h0003, 16'h0001, 16'h0023, 16'h0045, 16'h0000, 16'h0000, 16'h0100};
      exp_got = '{8'hA5, 8'h5A};
      lb = log0.size(); gb = got0.size(); db = done_cnt0;
      repeat (4) rxq0.push_back(8'hEE);
      rxq0.push_back(8'hA5);
      rxq0.push_back(8'h5A);
      rd_ready = 1'b1;
      start0(24'h012345, 16'd2);
      wait_done0(ok);
      vectors += 2;
      if (!ok) begin miscompares++; $display("[TB] FAIL first_done_timeout: got no done want done"); end
      if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL first_busy_at_done: got %b want 0", busy0); end
      repeat (3) @(negedge clk);
      vectors += 3;
      if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL first_busy_after: got %b want 0", busy0); end
      if (done_cnt0 - db !== 1) begin miscompares++; $display("[TB] FAIL first_done_count: got %0d want 1", done_cnt0 - db); end
      if (log0.size() - lb !== 8) begin miscompares++; $display("[TB] FAIL first_load_count: got %0d want 8", log0.size() - lb); end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (lb + i >= log0.size() || log0[lb + i] !== exp_log[i]) begin
            miscompares++;
            $display("[TB] FAIL first_spi_in[%0d]: got %h want %h", i, (lb + i < log0.size()) ? log0[lb + i] : 16'hxxxx, exp_log[i]);
         end
      end
      vectors++;
      if (got0.size() - gb !== 2) begin miscompares++; $display("[TB] FAIL first_byte_count: got %0d want 2", got0.size() - gb); end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (gb + i >= got0.size() || got0[gb + i] !== exp_got[i]) begin
            miscompares++;
            $display("[TB] FAIL first_rd_data[%0d]: got %h want %h", i, (gb + i < got0.size()) ? got0[gb + i] : 8'hxx, exp_got[i]);
         end
      end
   endtask

   task automatic test_no_predesel;
      logic [15:0] exp_log[6];
      int lb, gb;
      bit ok;
      exp_log = '{16'h0003, 16'h00AB, 16'h00CD, 16'h00EF, 16'h0000, 16'h0100};
      lb = log0.size(); gb = got0.size();
      while (rxq0.size() < m_idx0) rxq0.push_back(8'hEE);
      repeat (4) rxq0.push_back(8'hEE);
      rxq0.push_back(8'h3C);
      rd_ready = 1'b1;
      start0(24'hABCDEF, 16'd1);
      wait_done0(ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("[TB] FAIL second_done_timeout: got no done want done"); end
      if (log0.size() - lb !== 6) begin miscompares++; $display("[TB] FAIL second_load_count: got %0d want 6", log0.size() - lb); end
      if (got0.size() - gb !== 1 || got0[got0.size() - 1] !== 8'h3C) begin
         miscompares++; $display("[TB] FAIL second_rd_data: got %0d bytes last %h want 1 byte 3c", got0.size() - gb, got0[got0.size() - 1]);
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (lb + i >= log0.size() || log0[lb + i] !== exp_log[i]) begin
            miscompares++;
            $display("[TB] FAIL second_spi_in[%0d]: got %h want %h", i, (lb + i < log0.size()) ? log0[lb + i] : 16'hxxxx, exp_log[i]);
         end
      end
   endtask

   task automatic test_zero_len;
      int lb;
      lb = log0.size();
      @(negedge clk);
      req = 1'b1; addr = 24'h001000; len = 16'd0;
      @(negedge clk);
      req = 1'b0;
      vectors += 2;
      if (busy0 !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_busy_c1: got %b want 1", busy0); end
      if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_c1: got %b want 0", done0); end
      @(negedge clk);
      vectors += 2;
      if (done0 !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done_c2: got %b want 1", done0); end
      if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy_c2: got %b want 0", busy0); end
      @(negedge clk);
      vectors += 3;
      if (done0 !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_c3: got %b want 0", done0); end
      if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy_c3: got %b want 0", busy0); end
      if (log0.size() !== lb) begin miscompares++; $display("[TB] FAIL zero_load_count: got %0d want 0", log0.size() - lb); end
   endtask

   task automatic test_backpressure;
      logic [15:0] exp_log[8];
      logic [7:0]  exp_got[3];
      logic [7:0]  held;
      int lb, gb, ls;
      bit ok, stable;
      exp_log = '{16'h0003, 16'h0000, 16'h00FF, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0100};
      exp_got = '{8'h11, 8'h22, 8'h33};
      lb = log0.size(); gb = got0.size();
      while (rxq0.size() < m_idx0) rxq0.push_back(8'hEE);
      repeat (4) rxq0.push_back(8'hEE);
      rxq0.push_back(8'h11); rxq0.push_back(8'h22); rxq0.push_back(8'h33);
      rd_ready = 1'b0;
      start0(24'h00FF10, 16'd3);
      for (int b = 0; b < 3; b++) begin
         wait_valid0(ok);
         vectors++;
         if (!ok) begin miscompares++; $display("[TB] FAIL bp_valid_timeout[%0d]: got no rd_valid want rd_valid", b); end
         if (b == 1) begin
            held = rd_data0; ls = log0.size(); stable = 1'b1;
            repeat (10) begin
               @(negedge clk);
               if (rd_valid0 !== 1'b1 || rd_data0 !== held) stable = 1'b0;
            end
            vectors += 2;
            if (!stable) begin miscompares++; $display("[TB] FAIL bp_hold_stable: got unstable want stable %h", held); end
            if (log0.size() !== ls) begin miscompares++; $display("[TB] FAIL bp_load_in_stall: got %0d loads want 0", log0.size() - ls); end
         end
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
      wait_done0(ok);
      vectors += 2;
      if (!ok) begin miscompares++; $display("[TB] FAIL bp_done_timeout: got no done want done"); end
      if (got0.size() - gb !== 3) begin miscompares++; $display("[TB] FAIL bp_byte_count: got %0d want 3", got0.size() - gb); end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (gb + i >= got0.size() || got0[gb + i] !== exp_got[i]) begin
            miscompares++;
            $display("[TB] FAIL bp_rd_data[%0d]: got %h want %h", i, (gb + i < got0.size()) ? got0[gb + i] : 8'hxx, exp_got[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (lb + i >= log0.size() || log0[lb + i] !== exp_log[i]) begin
            miscompares++;
            $display("[TB] FAIL bp_spi_in[%0d]: got %h want %h", i, (lb + i < log0.size()) ? log0[lb + i] : 16'hxxxx, exp_log[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] exp_log[7];
      int lb, gb;
      bit ok;
      exp_log = '{16'h0100, 16'h0003, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 16'h0100};
      rd_ready = 1'b1;
      lb = log0.size();
      start0(24'h0A0B0C, 16'd1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (log0.size() >= lb + 2) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL mid_addr_timeout: got %0d loads want 2", log0.size() - lb); end
      #2 reset = 1'b1;
      #1;
      vectors += 5;
      if (busy0 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_busy: got %b want 0", busy0); end
      if (spi_load0 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_spi_load: got %b want 0", spi_load0); end
      if (rd_valid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_rd_valid: got %b want 0", rd_valid0); end
      if (rd_data0 !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_reset_rd_data: got %h want 00", rd_data0); end
      if (spi_in0 !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_reset_spi_in: got %h want 0000", spi_in0); end
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      while (rxq0.size() < m_idx0) rxq0.push_back(8'hEE);
      repeat (4) rxq0.push_back(8'hEE);
      rxq0.push_back(8'h77);
      lb = log0.size(); gb = got0.size();
      start0(24'h000102, 16'd1);
      wait_done0(ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("[TB] FAIL mid_done_timeout: got no done want done"); end
      if (log0.size() - lb !== 7) begin miscompares++; $display("[TB] FAIL mid_load_count: got %0d want 7", log0.size() - lb); end
      if (got0.size() - gb !== 1 || got0[got0.size() - 1] !== 8'h77) begin
         miscompares++; $display("[TB] FAIL mid_rd_data: got %0d bytes last %h want 1 byte 77", got0.size() - gb, got0[got0.size() - 1]);
      end
      for (int i = 0; i < 7; i++) begin
         vectors++;
         if (lb + i >= log0.size() || log0[lb + i] !== exp_log[i]) begin
            miscompares++;
            $display("[TB] FAIL mid_spi_in[%0d]: got %h want %h", i, (lb + i < log0.size()) ? log0[lb + i] : 16'hxxxx, exp_log[i]);
         end
      end
   endtask

   task automatic test_fast_read;
      logic [15:0] exp_log[8];
      int lb, gb;
      bit ok;
      exp_log = '{16'h0100, 16'h000B, 16'h0012, 16'h0034, 16'h0056, 16'h0000, 16'h0000, 16'h0100};
      lb = log1.size(); gb = got1.size();
      while (rxq1.size() < m_idx1) rxq1.push_back(8'hEE);
      repeat (4) rxq1.push_back(8'hEE);
      rxq1.push_back(8'hD0);
      rxq1.push_back(8'hC3);
      rd_ready1 = 1'b1;
      @(negedge clk);
      req1 = 1'b1; addr1 = 24'h123456; len1 = 16'd1;
      @(negedge clk);
      req1 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (done1) begin ok = 1'b1; break; end
      end
      vectors += 4;
      if (!ok) begin miscompares++; $display("[TB] FAIL fast_done_timeout: got no done want done"); end
      if (log1.size() - lb !== 8) begin miscompares++; $display("[TB] FAIL fast_load_count: got %0d want 8", log1.size() - lb); end
      if (got1.size() - gb !== 1) begin miscompares++; $display("[TB] FAIL fast_byte_count: got %0d want 1", got1.size() - gb); end
      if (got1.size() == 0 || got1[got1.size() - 1] !== 8'hC3) begin
         miscompares++; $display("[TB] FAIL fast_rd_data: got %h want c3", (got1.size() > 0) ? got1[got1.size() - 1] : 8'hxx);
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (lb + i >= log1.size() || log1[lb + i] !== exp_log[i]) begin
            miscompares++;
            $display("[TB] FAIL fast_spi_in[%0d]: got %h want %h", i, (lb + i < log1.size()) ? log1[lb + i] : 16'hxxxx, exp_log[i]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; req1 = 1'b0;
      addr = '0; addr1 = '0; len = '0; len1 = '0;
      rd_ready = 1'b0; rd_ready1 = 1'b0;
      test_reset();
      test_first_read();
      test_no_predesel();
      test_zero_len();
      test_backpressure();
      test_reset_mid();
      test_fast_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
